// File: rtl/branch_resolve_buffer.sv
// Branch resolve buffer: collects branch-FU resolutions, raises the oldest-mispredict redirect
// and drains predictor updates in arrival order. Optional counters: BRANCH_RESOLVE_STATS_EN.
module branch_resolve_buffer #(
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 1,
   parameter int DEPTH     = 8,
   parameter int PC_W      = 32,
   parameter int ROB_IDX_W = 5
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [IN_WIDTH-1:0]                  in_valid,
   input  logic [IN_WIDTH-1:0]                  in_taken,
   input  logic [IN_WIDTH-1:0]                  in_mispredict,
   input  logic [IN_WIDTH-1:0][PC_W-1:0]        in_source_pc,
   input  logic [IN_WIDTH-1:0][PC_W-1:0]        in_target_pc,
   input  logic [IN_WIDTH-1:0][ROB_IDX_W-1:0]   in_rob_index,
   output logic                                 in_ready,
   input  logic [ROB_IDX_W-1:0]                 rob_head,
   output logic                                 flush_valid,
   output logic [PC_W-1:0]                      flush_target_pc,
   output logic [ROB_IDX_W-1:0]                 flush_rob_index,
   output logic [OUT_WIDTH-1:0]                 out_valid,
   output logic [OUT_WIDTH-1:0][PC_W-1:0]       out_source_pc,
   output logic [OUT_WIDTH-1:0][PC_W-1:0]       out_target_pc,
   output logic [OUT_WIDTH-1:0]                 out_taken,
   input  logic                                 out_ready,
   output logic [31:0]                          stat_resolved,
   output logic [31:0]                          stat_mispredict
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0]     ptr_t;
   typedef logic [CNT_W-1:0]     cnt_t;
   typedef logic [ROB_IDX_W-1:0] rob_t;

   // Age relative to the ROB head; modular subtraction makes wrap-around transparent.
   function automatic rob_t ageOf(input rob_t idx, input rob_t origin);
      return idx - origin;
   endfunction

   logic [PC_W-1:0] src_q [DEPTH];
   logic [PC_W-1:0] tgt_q [DEPTH];
   rob_t            rob_q [DEPTH];
   logic [DEPTH-1:0] taken_q;
   logic [DEPTH-1:0] live_q, live_d;

   ptr_t head_q, tail_q;
   cnt_t count_q;

   logic            flush_valid_q, flush_valid_d;
   logic [PC_W-1:0] flush_tgt_q;
   rob_t            flush_rob_q;

   rob_t                flush_age;
   rob_t                lane_age [IN_WIDTH];
   cnt_t                lane_off [IN_WIDTH];
   logic [IN_WIDTH-1:0] acc;
   cnt_t                enq_cnt, deq_cnt;
   logic                cand_found;
   rob_t                cand_age, cand_rob;
   logic [PC_W-1:0]     cand_tgt;

   ptr_t                 win_slot [OUT_WIDTH];
   logic [OUT_WIDTH-1:0] win_occ;
   logic                 dead_run;

   assign in_ready        = ((cnt_t'(DEPTH) - count_q) >= cnt_t'(IN_WIDTH));
   assign flush_valid     = flush_valid_q;
   assign flush_target_pc = flush_tgt_q;
   assign flush_rob_index = flush_rob_q;

   // Lane acceptance, compaction offsets and selection of the oldest accepted mispredict.
   always_comb begin
      flush_age  = ageOf(flush_rob_q, rob_head);
      acc        = '0;
      enq_cnt    = '0;
      cand_found = 1'b0;
      cand_age   = '0;
      cand_rob   = '0;
      cand_tgt   = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         lane_age[i] = ageOf(in_rob_index[i], rob_head);
         lane_off[i] = enq_cnt;
         if (in_valid[i] && in_ready && !(flush_valid_q && (lane_age[i] > flush_age))) begin
            acc[i]  = 1'b1;
            enq_cnt = enq_cnt + cnt_t'(1);
            if (in_mispredict[i] && (!cand_found || (lane_age[i] < cand_age))) begin
               cand_found = 1'b1;
               cand_age   = lane_age[i];
               cand_rob   = in_rob_index[i];
               cand_tgt   = in_target_pc[i];
            end
         end
      end
      flush_valid_d = cand_found && (!flush_valid_q || (cand_age < flush_age));
   end

   // Output window; dead entries at the front are discarded even when the predictor stalls.
   always_comb begin
      deq_cnt       = '0;
      dead_run      = 1'b1;
      out_valid     = '0;
      out_source_pc = '0;
      out_target_pc = '0;
      out_taken     = '0;
      for (int k = 0; k < OUT_WIDTH; k++) begin
         win_slot[k]      = head_q + ptr_t'(k);
         win_occ[k]       = (cnt_t'(k) < count_q);
         out_valid[k]     = win_occ[k] && live_q[win_slot[k]];
         out_source_pc[k] = src_q[win_slot[k]];
         out_target_pc[k] = tgt_q[win_slot[k]];
         out_taken[k]     = taken_q[win_slot[k]];
         if (win_occ[k] && (out_ready || (dead_run && !live_q[win_slot[k]])))
            deq_cnt = deq_cnt + cnt_t'(1);
         if (!(win_occ[k] && !live_q[win_slot[k]]))
            dead_run = 1'b0;
      end
   end

   always_comb begin
      live_d = live_q;
      for (int k = 0; k < OUT_WIDTH; k++)
         if (cnt_t'(k) < deq_cnt)
            live_d[head_q + ptr_t'(k)] = 1'b0;
      if (flush_valid_q)
         for (int j = 0; j < DEPTH; j++)
            if (ageOf(rob_q[j], rob_head) > flush_age)
               live_d[j] = 1'b0;
      for (int i = 0; i < IN_WIDTH; i++)
         if (acc[i])
            live_d[tail_q + ptr_t'(lane_off[i])] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         live_q        <= '0;
         flush_valid_q <= 1'b0;
         flush_tgt_q   <= '0;
         flush_rob_q   <= '0;
      end else begin
         head_q        <= head_q + ptr_t'(deq_cnt);
         tail_q        <= tail_q + ptr_t'(enq_cnt);
         count_q       <= count_q + enq_cnt - deq_cnt;
         live_q        <= live_d;
         flush_valid_q <= flush_valid_d;
         if (flush_valid_d) begin
            flush_tgt_q <= cand_tgt;
            flush_rob_q <= cand_rob;
         end
      end
   end

   // Payload storage needs no reset: live bits alone decide what is meaningful.
   always_ff @(posedge clock) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (acc[i]) begin
            src_q[tail_q + ptr_t'(lane_off[i])]   <= in_source_pc[i];
            tgt_q[tail_q + ptr_t'(lane_off[i])]   <= in_target_pc[i];
            rob_q[tail_q + ptr_t'(lane_off[i])]   <= in_rob_index[i];
            taken_q[tail_q + ptr_t'(lane_off[i])] <= in_taken[i];
         end
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_res_q, stat_mp_q;
   cnt_t        mp_cnt;

   always_comb begin
      mp_cnt = '0;
      for (int i = 0; i < IN_WIDTH; i++)
         if (acc[i] && in_mispredict[i])
            mp_cnt = mp_cnt + cnt_t'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_res_q <= '0;
         stat_mp_q  <= '0;
      end else begin
         stat_res_q <= stat_res_q + 32'(enq_cnt);
         stat_mp_q  <= stat_mp_q + 32'(mp_cnt);
      end
   end

   assign stat_resolved   = stat_res_q;
   assign stat_mispredict = stat_mp_q;
`else
   assign stat_resolved   = '0;
   assign stat_mispredict = '0;
`endif

endmodule
